icache_assoc_fetch: RTL and testbench
=====================================

Name: icache_assoc_fetch

Overview:
Parametrised set-associative instruction cache and fetch controller; the next generation of the direct-mapped fetch MMU. It sits between the fetch stage (physical address, cached/uncached attribute) and mmu_top's burst read port. It returns up to two sequential instructions per cycle on a hit. It adds configurable geometry, per-set round-robin replacement, bulk invalidate and refill-error handling.

Parameters:
LINE_WORDS, 16, 32-bit words per line; power of two, 4..32
SETS, 128, sets; power of two, 16..512
WAYS, 2, ways per set; power of two, 1..4
OFF_W = log2(LINE_WORDS), IDX_W = log2(SETS), TAG_W = 30-OFF_W-IDX_W; derived via localparam, not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ien  in  1  fetch request; iaddr_psy/iaddr_type held stable while ien=1 and no inst_ok
iaddr_psy  in  32  physical fetch address, word aligned
iaddr_type  in  1  0 cached, 1 uncached
inv_all  in  1  invalidate whole cache (single-cycle pulse)
inst_ok  out  1  fetch complete this cycle
inst_ok_1  out  1  inst_data_1 valid
inst_ok_2  out  1  inst_data_2 valid
inst_data_1  out  32  instruction at iaddr_psy
inst_data_2  out  32  instruction at iaddr_psy+4
iaddr_req  out  32  bus request address
read_en  out  1  bus request valid
read_type  out  1  0 line refill, 1 uncached single word
read_len  out  8  beats minus one: LINE_WORDS-1 for refill, 0 for uncached
iaddr_req_ok  in  1  request accepted this cycle
idata_rdata  in  32  read data beat
idata_rvalid  in  1  beat valid
idata_rlast  in  1  final beat of burst

Behaviour:
- Reset: all outputs 0, state IDLE, all valid bits 0, round-robin pointers 0, beat counter 0.
- States: IDLE, C_SHAKE, C_REFILL, U_SHAKE, U_RETURN.
- IDLE, ien=0: no outputs.
- IDLE, ien=1, iaddr_type=1: drive read_en=1, read_type=1, iaddr_req=iaddr_psy. Go to U_RETURN if iaddr_req_ok, else U_SHAKE.
- IDLE, ien=1, cached: tag/valid lookup across all ways, combinational, same cycle.
- Hit: inst_ok=inst_ok_1=1. inst_ok_2=1 unless offset==LINE_WORDS-1 (no cross-line pair). Data from the hit way. Zero-cycle latency; stay IDLE.
- More than one hitting way is illegal; assertion in simulation.
- Miss: read_en=1, read_type=0, iaddr_req={tag,index,OFF_W+2 zero bits}. Go to C_REFILL if accepted, else C_SHAKE.
- Victim is chosen at miss: lowest-numbered invalid way, else the set's round-robin pointer. It is latched for the whole refill.
- C_SHAKE / U_SHAKE: hold the request until iaddr_req_ok, then move to C_REFILL / U_RETURN.
- C_REFILL: each rvalid beat writes word[beat_cnt] of the victim way; beat_cnt increments and wraps at LINE_WORDS.
  - On rlast with beat_cnt==LINE_WORDS-1: set tag, set valid, advance the set's pointer (mod WAYS), go IDLE.
  - The original fetch then hits on the next cycle (miss penalty = bus latency + 1).
  - rlast early or late (beat_cnt mismatch): line stays invalid, go IDLE; the fetch re-misses.
- U_RETURN: inst_ok=inst_ok_1=idata_rvalid, inst_data_1=idata_rdata, inst_ok_2=0. Go IDLE on rlast.
- inv_all in IDLE: all valid bits cleared next edge; any hit in that same cycle is still reported.
- inv_all during C_SHAKE/C_REFILL: latched as pending. The refilling line is not validated, and all valid bits clear when returning to IDLE.
- inv_all during U_SHAKE/U_RETURN: latched as pending and applied on return to IDLE.
- rst mid-burst: immediate IDLE. Remaining bus beats are ignored (rvalid outside C_REFILL/U_RETURN is discarded).
- Data array: one 32-bit word per way per (index, offset). Async dual read at offset and offset+1 (the offset+1 address does not carry into the index). Sync write.

Optional Feature:
ICACHE_PERF_CNT_EN:
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Each counter increments once per cached IDLE lookup that hits or misses (not per SHAKE cycle), saturates at 0xFFFFFFFF, and is reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Cold fetch 0x0000_1000 cached, bus accepts immediately, 16 beats 0x100+i -> read_en with iaddr_req=0x1000, read_len=15; next cycle after rlast inst_ok=1, data_1=0x100, data_2=0x101, inst_ok_2=1.
- Fetch 0x0000_103C after the fill -> hit same cycle, inst_ok_1=1, data_1=0x10F, inst_ok_2=0.
- WAYS=2: fill 0x1000, 0x3000, 0x5000 (same index) -> third refill evicts way 0; 0x1000 then misses and 0x3000 still hits.
- Uncached 0x1FC0_0000, iaddr_req_ok delayed 3 cycles, beat 0xDEADBEEF -> read_type=1, read_len=0, inst_ok=inst_ok_1=1 with data_1=0xDEADBEEF, inst_ok_2=0.
- inv_all pulse at beat 5 of a refill of 0x2000 -> burst completes, back in IDLE, fetch 0x2000 misses again; a previously cached 0x1000 also misses.
- rlast on beat 7 of 16 -> line not valid, immediate re-miss of the same address; with ICACHE_PERF_CNT_EN miss_cnt=2, hit_cnt=0.

Source files
------------

// File: rtl/icache_assoc_fetch.sv
// Set-associative instruction cache and fetch controller with round-robin replacement.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module icache_assoc_fetch #(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned SETS       = 128,
    parameter int unsigned WAYS       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ien,
    input  logic [31:0] iaddr_psy,
    input  logic        iaddr_type,
    input  logic        inv_all,
    output logic        inst_ok,
    output logic        inst_ok_1,
    output logic        inst_ok_2,
    output logic [31:0] inst_data_1,
    output logic [31:0] inst_data_2,
    output logic [31:0] iaddr_req,
    output logic        read_en,
    output logic        read_type,
    output logic [7:0]  read_len,
    input  logic        iaddr_req_ok,
    input  logic [31:0] idata_rdata,
    input  logic        idata_rvalid,
    input  logic        idata_rlast
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned TAG_W   = 30 - OFF_W - IDX_W;
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_LSB = OFF_W + IDX_W + 2;

    typedef enum logic [2:0] {StIdle, StCShake, StCRefill, StUShake, StUReturn} state_e;

    state_e           state_q;
    logic [SETS-1:0]  valid_q [WAYS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS*LINE_WORDS];
    logic [WAY_W-1:0] rr_q    [SETS];
    logic [WAY_W-1:0] victim_q, victim;
    logic [OFF_W-1:0] beat_cnt_q;
    logic [31:0]      req_addr_q;
    logic             inv_pend_q;

    logic [OFF_W-1:0] off, off_nxt;
    logic [IDX_W-1:0] idx, ref_idx;
    logic [TAG_W-1:0] tag, ref_tag;
    logic [31:0]      line_addr, hit_d1, hit_d2;
    logic [WAYS-1:0]  hit_vec;
    logic             hit, lookup, inv_now;
    logic [WAY_W-1:0] rr_next;
    logic             unused_addr_bits;

    assign off              = iaddr_psy[OFF_W+1:2];
    assign off_nxt          = off + 1'b1;
    assign idx              = iaddr_psy[TAG_LSB-1:OFF_W+2];
    assign tag              = iaddr_psy[31:TAG_LSB];
    assign line_addr        = {tag, idx, {(OFF_W + 2){1'b0}}};
    assign ref_idx          = req_addr_q[TAG_LSB-1:OFF_W+2];
    assign ref_tag          = req_addr_q[31:TAG_LSB];
    assign hit              = |hit_vec;
    assign lookup           = (state_q == StIdle) && ien && !iaddr_type;
    assign inv_now          = inv_pend_q | inv_all;
    assign rr_next          = WAY_W'((32'(rr_q[ref_idx]) + 32'd1) % WAYS);
    assign unused_addr_bits = ^iaddr_psy[1:0];

    always_comb begin
        hit_vec = '0;
        hit_d1  = '0;
        hit_d2  = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
            if (hit_vec[w]) begin
                hit_d1 = data_q[w][{idx, off}];
                hit_d2 = data_q[w][{idx, off_nxt}];
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise fall back to the set's round-robin pointer.
    always_comb begin
        victim = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            victim_q   <= '0;
            beat_cnt_q <= '0;
            inv_pend_q <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inv_all) for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                    if (ien && iaddr_type) begin
                        req_addr_q <= iaddr_psy;
                        state_q    <= iaddr_req_ok ? StUReturn : StUShake;
                    end else if (ien && !hit) begin
                        // Victim is dropped now so a partial or aborted fill never looks valid.
                        req_addr_q              <= line_addr;
                        victim_q                <= victim;
                        valid_q[victim][idx]    <= 1'b0;
                        state_q                 <= iaddr_req_ok ? StCRefill : StCShake;
                    end
                end
                StCShake: begin
                    inv_pend_q <= inv_now;
                    if (iaddr_req_ok) state_q <= StCRefill;
                end
                StCRefill: begin
                    inv_pend_q <= inv_now;
                    if (idata_rvalid) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (idata_rlast) begin
                            beat_cnt_q <= '0;
                            inv_pend_q <= 1'b0;
                            state_q    <= StIdle;
                            if (inv_now) begin
                                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                            end else if (beat_cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                                tag_q[victim_q][ref_idx]   <= ref_tag;
                                valid_q[victim_q][ref_idx] <= 1'b1;
                                rr_q[ref_idx]              <= rr_next;
                            end
                        end
                    end
                end
                StUShake: begin
                    inv_pend_q <= inv_now;
                    if (iaddr_req_ok) state_q <= StUReturn;
                end
                StUReturn: begin
                    inv_pend_q <= inv_now;
                    if (idata_rvalid && idata_rlast) begin
                        inv_pend_q <= 1'b0;
                        state_q    <= StIdle;
                        if (inv_now) for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == StCRefill && idata_rvalid) begin
            data_q[victim_q][{ref_idx, beat_cnt_q}] <= idata_rdata;
        end
    end

    always_comb begin
        inst_ok     = 1'b0;
        inst_ok_1   = 1'b0;
        inst_ok_2   = 1'b0;
        inst_data_1 = '0;
        inst_data_2 = '0;
        iaddr_req   = '0;
        read_en     = 1'b0;
        read_type   = 1'b0;
        read_len    = '0;
        unique case (state_q)
            StIdle: begin
                if (ien && iaddr_type) begin
                    read_en   = 1'b1;
                    read_type = 1'b1;
                    iaddr_req = iaddr_psy;
                end else if (ien && hit) begin
                    inst_ok     = 1'b1;
                    inst_ok_1   = 1'b1;
                    inst_data_1 = hit_d1;
                    inst_ok_2   = (off != OFF_W'(LINE_WORDS - 1));
                    inst_data_2 = inst_ok_2 ? hit_d2 : '0;
                end else if (ien) begin
                    read_en   = 1'b1;
                    read_len  = 8'(LINE_WORDS - 1);
                    iaddr_req = line_addr;
                end
            end
            StCShake: begin
                read_en   = 1'b1;
                read_len  = 8'(LINE_WORDS - 1);
                iaddr_req = req_addr_q;
            end
            StUShake: begin
                read_en   = 1'b1;
                read_type = 1'b1;
                iaddr_req = req_addr_q;
            end
            StUReturn: begin
                inst_ok     = idata_rvalid;
                inst_ok_1   = idata_rvalid;
                inst_data_1 = idata_rvalid ? idata_rdata : '0;
            end
            default: ;
        endcase
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (lookup) begin
            if (hit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            if (!hit && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

    a_single_hit: assert property (@(posedge clk) disable iff (rst) lookup |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_icache_assoc_fetch.sv
// Randomized bench for icache_assoc_fetch against a line-level cache model (default geometry).
module tb_icache_assoc_fetch;
    localparam int LW    = 16;
    localparam int NSETS = 128;
    localparam int NWAYS = 2;
    localparam int OFFB  = 6;

    logic        clk = 1'b0;
    logic        rst, ien, iaddr_type, inv_all, iaddr_req_ok, idata_rvalid, idata_rlast;
    logic [31:0] iaddr_psy, idata_rdata;
    logic        inst_ok, inst_ok_1, inst_ok_2, read_en, read_type;
    logic [31:0] inst_data_1, inst_data_2, iaddr_req;
    logic [7:0]  read_len;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_assoc_fetch dut (
`ifdef ICACHE_PERF_CNT_EN
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
`endif
        .clk          (clk),
        .rst          (rst),
        .ien          (ien),
        .iaddr_psy    (iaddr_psy),
        .iaddr_type   (iaddr_type),
        .inv_all      (inv_all),
        .inst_ok      (inst_ok),
        .inst_ok_1    (inst_ok_1),
        .inst_ok_2    (inst_ok_2),
        .inst_data_1  (inst_data_1),
        .inst_data_2  (inst_data_2),
        .iaddr_req    (iaddr_req),
        .read_en      (read_en),
        .read_type    (read_type),
        .read_len     (read_len),
        .iaddr_req_ok (iaddr_req_ok),
        .idata_rdata  (idata_rdata),
        .idata_rvalid (idata_rvalid),
        .idata_rlast  (idata_rlast)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: which line address each way of each set holds, plus replacement pointers.
    bit          m_valid [NWAYS][NSETS];
    logic [31:0] m_line  [NWAYS][NSETS];
    int          m_rr    [NSETS];
    int          exp_hit, exp_miss;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:6], 2'b00, a[31:8], a[5:2]};
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> OFFB) & 32'(NSETS - 1));
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        for (int w = 0; w < NWAYS; w++)
            if (m_valid[w][set_of(a)] && m_line[w][set_of(a)] == line_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < NWAYS; w++) if (!m_valid[w][s]) return w;
        return m_rr[s];
    endfunction

    task automatic m_clear();
        for (int w = 0; w < NWAYS; w++) for (int s = 0; s < NSETS; s++) m_valid[w][s] = 1'b0;
    endtask

    task automatic m_reset();
        m_clear();
        for (int s = 0; s < NSETS; s++) m_rr[s] = 0;
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic check_perf();
`ifdef ICACHE_PERF_CNT_EN
        check_eq("hit_cnt", hit_cnt, exp_hit);
        check_eq("miss_cnt", miss_cnt, exp_miss);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; ien = 1'b0; inv_all = 1'b0; iaddr_req_ok = 1'b0;
        idata_rvalid = 1'b0; idata_rlast = 1'b0; idata_rdata = '0;
        iaddr_psy = '0; iaddr_type = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_inst_ok", inst_ok, 0);
        check_eq("rst_read_en", read_en, 0);
        check_eq("rst_data_1", inst_data_1, 0);
        check_eq("rst_iaddr_req", iaddr_req, 0);
        check_eq("rst_read_len", read_len, 0);
        m_reset();
        check_perf();
        rst = 1'b0;
    endtask

    // One complete fetch, starting just after a falling edge and ending on one.
    // n_first/inv_beat shape only the first bus transaction; re-misses get clean full bursts.
    task automatic fetch(input logic [31:0] a, input logic unc, input int ok_dly, input int n_first,
                         input int inv_beat, input logic inv_idle, input logic [31:0] u_data);
        int   s, v, n, ib, nb;
        logic inv_i;
        bit   done;
        s = set_of(a); v = 0; n = n_first; ib = inv_beat; inv_i = inv_idle; done = 1'b0;
        ien = 1'b1; iaddr_psy = a; iaddr_type = unc; inv_all = inv_idle;
        for (int r = 0; r < 4 && !done; r++) begin
            #1;
            if (!unc && m_hit(a)) begin
                check_eq("hit_ok", inst_ok, 1);
                check_eq("hit_ok_1", inst_ok_1, 1);
                check_eq("hit_data_1", inst_data_1, mem_word(a));
                check_eq("hit_ok_2", inst_ok_2, (a[5:2] != 4'hF));
                if (a[5:2] != 4'hF) check_eq("hit_data_2", inst_data_2, mem_word(a + 4));
                check_eq("hit_read_en", read_en, 0);
                exp_hit++;
                if (inv_i) m_clear();
                @(posedge clk); #1;
                ien = 1'b0; inv_all = 1'b0;
                @(negedge clk);
                check_perf();
                done = 1'b1;
            end else begin
                check_eq("req_inst_ok", inst_ok, 0);
                check_eq("req_read_en", read_en, 1);
                check_eq("req_read_type", read_type, unc);
                check_eq("req_read_len", read_len, unc ? 0 : LW - 1);
                check_eq("req_addr", iaddr_req, unc ? a : line_of(a));
                if (!unc) begin
                    v = m_victim(s);
                    m_valid[v][s] = 1'b0;
                    exp_miss++;
                end
                if (inv_i) m_clear();
                inv_i = 1'b0;
                iaddr_req_ok = (ok_dly == 0);
                for (int k = 0; k < ok_dly; k++) begin
                    @(negedge clk); inv_all = 1'b0; #1;
                    if (k == 0) begin
                        check_eq("shake_read_en", read_en, 1);
                        check_eq("shake_addr", iaddr_req, unc ? a : line_of(a));
                    end
                    if (k == ok_dly - 1) iaddr_req_ok = 1'b1;
                end
                @(negedge clk);
                iaddr_req_ok = 1'b0; inv_all = 1'b0;
                check_perf();
                nb = unc ? 1 : n;
                for (int i = 0; i < nb; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    idata_rvalid = 1'b1;
                    idata_rdata  = unc ? u_data : mem_word(line_of(a) + 32'(4 * (i % LW)));
                    idata_rlast  = (i == nb - 1);
                    inv_all      = (i == ib);
                    #1;
                    if (unc) begin
                        check_eq("unc_ok", inst_ok, 1);
                        check_eq("unc_ok_1", inst_ok_1, 1);
                        check_eq("unc_data_1", inst_data_1, u_data);
                        check_eq("unc_ok_2", inst_ok_2, 0);
                    end else if (i == 0) begin
                        check_eq("fill_inst_ok", inst_ok, 0);
                        check_eq("fill_read_en", read_en, 0);
                    end
                    @(negedge clk);
                    idata_rvalid = 1'b0; idata_rlast = 1'b0; inv_all = 1'b0;
                end
                if (ib >= 0 && ib < nb) m_clear();
                else if (!unc && n == LW) begin
                    m_valid[v][s] = 1'b1;
                    m_line[v][s]  = line_of(a);
                    m_rr[s]       = (m_rr[s] + 1) % NWAYS;
                end
                if (unc) begin
                    ien  = 1'b0;
                    done = 1'b1;
                end
                n  = LW;
                ib = -1;
            end
        end
        check_eq("fetch_done", 32'(done), 1);
        ien = 1'b0;
    endtask

    initial begin
        int n, ib;
        logic [31:0] a;
        do_reset();

        fetch(32'h0000_1000, 1'b0, 0, LW, -1, 1'b0, '0);
        fetch(32'h0000_103C, 1'b0, 0, LW, -1, 1'b0, '0);
        fetch(32'h0000_3000, 1'b0, 1, LW, -1, 1'b0, '0);
        fetch(32'h0000_5000, 1'b0, 2, LW, -1, 1'b0, '0);
        fetch(32'h0000_3008, 1'b0, 0, LW, -1, 1'b0, '0);
        fetch(32'h0000_1000, 1'b0, 0, LW, -1, 1'b0, '0);
        fetch(32'h1FC0_0000, 1'b1, 3, 1, -1, 1'b0, 32'hDEAD_BEEF);
        fetch(32'h0000_2000, 1'b0, 1, LW, 5, 1'b0, '0);
        fetch(32'h0000_1000, 1'b0, 0, LW, -1, 1'b0, '0);

        do_reset();
        fetch(32'h0000_4000, 1'b0, 0, 8, -1, 1'b0, '0);

        // Reset in the middle of a burst; the tail of that burst must be ignored.
        ien = 1'b1; iaddr_psy = 32'h0000_6000; iaddr_type = 1'b0; iaddr_req_ok = 1'b1;
        #1 check_eq("rb_read_en", read_en, 1);
        @(negedge clk);
        iaddr_req_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idata_rvalid = 1'b1; idata_rdata = 32'hBAD0_0000 + i;
            @(negedge clk);
        end
        idata_rvalid = 1'b0; rst = 1'b1; ien = 1'b0;
        @(negedge clk); #1;
        check_eq("rb_rst_read_en", read_en, 0);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 5; i++) begin
            idata_rvalid = 1'b1; idata_rlast = (i == 4); idata_rdata = 32'hBAD1_0000 + i;
            #1;
            check_eq("rb_tail_inst_ok", inst_ok, 0);
            check_eq("rb_tail_read_en", read_en, 0);
            @(negedge clk);
        end
        idata_rvalid = 1'b0; idata_rlast = 1'b0;
        check_perf();
        fetch(32'h0000_6000, 1'b0, 0, LW, -1, 1'b0, '0);
        fetch(32'h0000_6004, 1'b0, 0, LW, -1, 1'b1, '0);
        fetch(32'h0000_6000, 1'b0, 0, LW, -1, 1'b0, '0);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                ib = ($urandom_range(0, 5) == 0) ? 0 : -1;
                fetch(32'h1FC0_0000 | 32'($urandom_range(0, 255) << 2), 1'b1,
                      int'($urandom_range(0, 3)), 1, ib, ($urandom_range(0, 9) == 0), $urandom);
            end else begin
                a = 32'($urandom_range(0, 3) << 13) | 32'(($urandom_range(0, 1) != 0 ? 77 : 3) << 6)
                    | 32'($urandom_range(0, 15) << 2);
                case ($urandom_range(0, 9))
                    0:       n = int'($urandom_range(1, 15));
                    1:       n = LW + 1;
                    default: n = LW;
                endcase
                ib = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
                fetch(a, 1'b0, int'($urandom_range(0, 3)), n, ib, ($urandom_range(0, 9) == 0), '0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
